// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES round-controller definitions: step codes, round counts and key-length encodings.
// Imported by the controller and its round counter.
package aes_round_ctrl_pkg;

    typedef enum logic [2:0] {
        StRes = 3'b000,
        StStl = 3'b001,
        StAdd = 3'b010,
        StSub = 3'b011,
        StShi = 3'b100,
        StMix = 3'b101,
        StInv = 3'b110,
        StFin = 3'b111
    } cs_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] KEY_LEN_128 = 2'b00;
    localparam logic [1:0] KEY_LEN_192 = 2'b01;
    localparam logic [1:0] KEY_LEN_256 = 2'b10;
    localparam logic [1:0] KEY_LEN_ILL = 2'b11;

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        logic [3:0] nr;
        case (key_len)
            KEY_LEN_192: nr = NR_192;
            KEY_LEN_256: nr = NR_256;
            default:     nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round counter with clear/increment/hold and comparison flags against the latched round count.
module aes_round_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [3:0]       i_nr,
    output logic [CNT_W-1:0] o_cot,
    output logic             o_is_zero,
    output logic             o_is_last,
    output logic             o_is_pre_last
);

    logic [CNT_W-1:0] r_cot;
    logic [CNT_W-1:0] w_nr;

    assign w_nr = CNT_W'(i_nr);

    // Clear wins over increment; neither asserted means hold.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_cot <= '0;
        end else if (i_clr) begin
            r_cot <= '0;
        end else if (i_inc) begin
            r_cot <= r_cot + CNT_W'(1);
        end
    end

    assign o_cot         = r_cot;
    assign o_is_zero     = (r_cot == '0);
    assign o_is_last     = (r_cot == w_nr);
    assign o_is_pre_last = (r_cot == (w_nr - CNT_W'(1)));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer: drives step code and round counter for encrypt and decrypt,
// with optional inverse key-expansion pre-phase, start/busy/done handshake and stall.
module aes_round_ctrl
    import aes_round_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned KEY_PRE = 1
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic             i_start,
    input  logic             i_dec,
    input  logic [1:0]       i_key_len,
    input  logic             i_stall,
    output logic [2:0]       o_cs,
    output logic [CNT_W-1:0] o_cot,
    output logic [3:0]       o_nr,
    output logic             o_mode_dec,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    cs_e        r_cs;
    cs_e        w_cs_d;
    logic [3:0] r_nr;
    logic       r_mode_dec;
    logic       r_err;

    logic       w_idle;
    logic       w_launch;
    logic       w_err_d;
    logic       w_clr;
    logic       w_inc;
    logic       w_is_zero;
    logic       w_is_last;
    logic       w_is_pre_last;

    aes_round_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .i_clk        (i_clk),
        .i_res        (i_res),
        .i_clr        (w_clr),
        .i_inc        (w_inc),
        .i_nr         (r_nr),
        .o_cot        (o_cot),
        .o_is_zero    (w_is_zero),
        .o_is_last    (w_is_last),
        .o_is_pre_last(w_is_pre_last)
    );

    assign w_idle   = (r_cs == StRes) || (r_cs == StFin);
    assign w_launch = w_idle && i_start && (i_key_len != KEY_LEN_ILL);
    assign w_err_d  = w_idle && i_start && (i_key_len == KEY_LEN_ILL);

    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_cs       <= StRes;
            r_nr       <= NR_128;
            r_mode_dec <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cs  <= w_cs_d;
            r_err <= w_err_d;
            if (w_launch) begin
                r_nr       <= nr_of(i_key_len);
                r_mode_dec <= i_dec;
            end
        end
    end

    always_comb begin
        w_cs_d = r_cs;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        if (w_idle) begin
            if (w_launch) begin
                w_cs_d = (i_dec && (KEY_PRE != 0)) ? StInv : StStl;
                w_clr  = 1'b1;
            end
        end else if (!i_stall) begin
            case (r_cs)
                StInv: begin
                    if (w_is_pre_last) begin
                        w_cs_d = StStl;
                        w_clr  = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
                StStl: w_cs_d = StAdd;
                StAdd: begin
                    if (w_is_last) begin
                        w_cs_d = StFin;
                    end else if (!r_mode_dec) begin
                        w_cs_d = StSub;
                        w_inc  = 1'b1;
                    end else begin
                        // Decrypt skips MIX on the first round.
                        w_cs_d = w_is_zero ? StShi : StMix;
                    end
                end
                StSub: w_cs_d = r_mode_dec ? StAdd : StShi;
                StShi: begin
                    if (r_mode_dec) begin
                        w_cs_d = StSub;
                        w_inc  = 1'b1;
                    end else begin
                        w_cs_d = w_is_last ? StAdd : StMix;
                    end
                end
                StMix: w_cs_d = r_mode_dec ? StShi : StAdd;
                default: begin
                    w_cs_d = StRes;
                    w_clr  = 1'b1;
                end
            endcase
        end
    end

    assign o_cs       = r_cs;
    assign o_nr       = r_nr;
    assign o_mode_dec = r_mode_dec;
    assign o_busy     = !w_idle;
    assign o_done     = (r_cs == StFin);
    assign o_err      = r_err;

endmodule
